// File: rtl/ac_sequencer.sv
// Accumulator/E-flag sequencer: drives ALU operands and opcode, captures the result into AC/E.
// Rotates run through E one bit per cycle. done pulses when AC/E hold the final value.
module ac_sequencer #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [3:0]            cmd_count,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [2:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_carry,
  output logic [DATA_WIDTH-1:0] ac,
  output logic                  e,
  output logic                  done,
  output logic                  flag_zero,
  output logic                  flag_neg
);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_LDA = 4'd2;
  localparam logic [3:0] OP_CMA = 4'd3;
  localparam logic [3:0] OP_INC = 4'd4;
  localparam logic [3:0] OP_CLA = 4'd5;
  localparam logic [3:0] OP_CLE = 4'd6;
  localparam logic [3:0] OP_CME = 4'd7;
  localparam logic [3:0] OP_CIR = 4'd8;
  localparam logic [3:0] OP_CIL = 4'd9;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_CMA = 3'b010;
  localparam logic [2:0] ALU_TRN = 3'b101;
  localparam logic [2:0] ALU_INC = 3'b110;
  localparam logic [2:0] ALU_CLA = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ROT  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] ac_d;
  logic                  e_d;
  logic [2:0]            alu_op_d;
  logic                  accept;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    ac_d      = ac;
    e_d       = e;
    alu_op_d  = alu_op;
    cmd_ready = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        accept    = cmd_valid;
        if (accept) begin
          op_d   = cmd_op;
          cnt_d  = cmd_count;
          data_d = cmd_data;
          // Non-ALU commands leave alu_op at its previous value.
          case (cmd_op)
            OP_AND:  alu_op_d = ALU_AND;
            OP_ADD:  alu_op_d = ALU_ADD;
            OP_LDA:  alu_op_d = ALU_TRN;
            OP_CMA:  alu_op_d = ALU_CMA;
            OP_INC:  alu_op_d = ALU_INC;
            OP_CLA:  alu_op_d = ALU_CLA;
            default: alu_op_d = alu_op;
          endcase
          if ((cmd_op == OP_CIR || cmd_op == OP_CIL) && cmd_count != 4'd0)
            state_d = ROT;
          else
            state_d = EXEC;
        end
      end

      EXEC: begin
        case (op_q)
          OP_AND, OP_LDA, OP_CMA, OP_CLA: ac_d = alu_result;
          OP_ADD, OP_INC: begin
            ac_d = alu_result;
            e_d  = alu_carry;
          end
          OP_CLE:  e_d = 1'b0;
          OP_CME:  e_d = ~e;
          default: ;
        endcase
        state_d = DONE;
      end

      ROT: begin
        // E acts as a 17th bit of a circular register {E, AC}.
        if (op_q == OP_CIR) begin
          ac_d = {e, ac[DATA_WIDTH-1:1]};
          e_d  = ac[0];
        end else begin
          ac_d = {ac[DATA_WIDTH-2:0], e};
          e_d  = ac[DATA_WIDTH-1];
        end
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1)
          state_d = DONE;
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 4'd0;
      cnt_q   <= 4'd0;
      data_q  <= '0;
      ac      <= '0;
      e       <= 1'b0;
      alu_op  <= ALU_CLA;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ac      <= ac_d;
      e       <= e_d;
      alu_op  <= alu_op_d;
    end
  end

  assign alu_a     = ac;
  assign alu_b     = data_q;
  assign flag_zero = (ac == '0);
  assign flag_neg  = ac[DATA_WIDTH-1];

endmodule

// File: tb/tb_ac_sequencer.sv
// Bench for ac_sequencer: behavioural ALU, vector table, hand-written corner sequences and
// randomized commands checked against a {E,AC} rotate/arith reference model.
module tb_ac_sequencer;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [3:0]   cmd_count;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_op;
  logic         alu_carry;
  logic [W-1:0] ac;
  logic         e, done, flag_zero, flag_neg;

  ac_sequencer #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_count(cmd_count),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .ac(ac), .e(e), .done(done), .flag_zero(flag_zero), .flag_neg(flag_neg)
  );

  always #5 clk = ~clk;

  // Behavioural single-cycle ALU
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    case (alu_op)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b010: alu_result = ~alu_a;
      3'b101: alu_result = alu_b;
      3'b110: {alu_carry, alu_result} = {1'b0, alu_a} + 17'd1;
      default: alu_result = '0;
    endcase
  end

  int total = 0;
  int bad   = 0;
  logic [W-1:0] ac_m;
  logic         e_m;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] d;
    logic [3:0]   c;
    logic [W-1:0] exp_ac;
    logic         exp_e;
  } vec_t;
  vec_t vt[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: treat {E,AC} as a 17-bit word; rotates are plain circular shifts of it.
  task automatic model(input logic [3:0] op, input logic [W-1:0] d, input logic [3:0] c);
    logic [W:0] v;
    int         sh;
    v  = {e_m, ac_m};
    sh = int'(c);
    case (op)
      4'd0: ac_m = ac_m & d;
      4'd1: {e_m, ac_m} = {1'b0, ac_m} + {1'b0, d};
      4'd2: ac_m = d;
      4'd3: ac_m = ~ac_m;
      4'd4: {e_m, ac_m} = {1'b0, ac_m} + 17'd1;
      4'd5: ac_m = '0;
      4'd6: e_m = 1'b0;
      4'd7: e_m = ~e_m;
      4'd8: begin v = (v >> sh) | (v << (W + 1 - sh)); {e_m, ac_m} = v; end
      4'd9: begin v = (v << sh) | (v >> (W + 1 - sh)); {e_m, ac_m} = v; end
      default: ;
    endcase
  endtask

  // Issue one command from an idle sample point; returns in the done cycle.
  task automatic run_cmd(input logic [3:0] op, input logic [W-1:0] d, input logic [3:0] c);
    int n, exp_lat;
    exp_lat = ((op == 4'd8 || op == 4'd9) && c != 4'd0) ? int'(c) + 1 : 2;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_count = c;
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    check("accept_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("busy_ready", 32'(cmd_ready), 32'd0);
    n = 1;
    while (!done && n < 40) begin tick(); n++; end
    check("done_latency", 32'(n), 32'(exp_lat));
    model(op, d, c);
  endtask

  task automatic after_done();
    tick();
    check("pulse_end_done", 32'(done), 32'd0);
    check("ready_again", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int acc;
    logic [3:0]   rop;
    logic [W-1:0] rd;
    logic [3:0]   rc;

    vt[0]  = '{4'd2,  16'h7FFF, 4'd0, 16'h7FFF, 1'b0};
    vt[1]  = '{4'd4,  16'h0000, 4'd0, 16'h8000, 1'b0};
    vt[2]  = '{4'd2,  16'hFFFF, 4'd0, 16'hFFFF, 1'b0};
    vt[3]  = '{4'd1,  16'h0001, 4'd0, 16'h0000, 1'b1};
    vt[4]  = '{4'd0,  16'h0000, 4'd0, 16'h0000, 1'b1};
    vt[5]  = '{4'd2,  16'hA000, 4'd0, 16'hA000, 1'b1};
    vt[6]  = '{4'd6,  16'h0000, 4'd0, 16'hA000, 1'b0};
    vt[7]  = '{4'd9,  16'h0000, 4'd3, 16'h0002, 1'b1};
    vt[8]  = '{4'd7,  16'h0000, 4'd0, 16'h0002, 1'b0};
    vt[9]  = '{4'd7,  16'h0000, 4'd0, 16'h0002, 1'b1};
    vt[10] = '{4'd12, 16'hFFFF, 4'd5, 16'h0002, 1'b1};
    vt[11] = '{4'd3,  16'h0000, 4'd0, 16'hFFFD, 1'b1};
    vt[12] = '{4'd5,  16'h1234, 4'd0, 16'h0000, 1'b1};
    vt[13] = '{4'd8,  16'h0000, 4'd0, 16'h0000, 1'b1};
    vt[14] = '{4'd2,  16'h0001, 4'd0, 16'h0001, 1'b1};
    vt[15] = '{4'd8,  16'h0000, 4'd1, 16'h8000, 1'b1};
    vt[16] = '{4'd9,  16'h0000, 4'd2, 16'h0003, 1'b0};
    vt[17] = '{4'd1,  16'hFFFE, 4'd0, 16'h0001, 1'b1};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_count = '0;
    tick(); tick();
    check("rst_ac", 32'(ac), 32'h0);
    check("rst_e", 32'(e), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd7);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_zero", 32'(flag_zero), 32'd1);
    check("rst_neg", 32'(flag_neg), 32'd0);
    rst = 1'b0;
    ac_m = '0; e_m = 1'b0;
    tick();

    for (int i = 0; i < 18; i++) begin
      run_cmd(vt[i].op, vt[i].d, vt[i].c);
      check("vec_ac", 32'(ac), 32'(vt[i].exp_ac));
      check("vec_e", 32'(e), 32'(vt[i].exp_e));
      check("vec_zero", 32'(flag_zero), 32'(vt[i].exp_ac == '0));
      check("vec_neg", 32'(flag_neg), 32'(vt[i].exp_ac[W-1]));
      after_done();
    end

    // CIL by 3 from A000/E=0, observing each intermediate step
    run_cmd(4'd2, 16'hA000, 4'd0); after_done();
    run_cmd(4'd6, 16'h0000, 4'd0); after_done();
    cmd_valid = 1'b1; cmd_op = 4'd9; cmd_data = '0; cmd_count = 4'd3;
    tick();
    cmd_valid = 1'b0;
    check("cil_k1_ready", 32'(cmd_ready), 32'd0);
    check("cil_k1_ac", 32'(ac), 32'hA000);
    tick();
    check("cil_k2_ac", 32'(ac), 32'h4000);
    check("cil_k2_e", 32'(e), 32'd1);
    tick();
    check("cil_k3_ac", 32'(ac), 32'h8001);
    check("cil_k3_e", 32'(e), 32'd0);
    check("cil_k3_done", 32'(done), 32'd0);
    tick();
    check("cil_k4_ac", 32'(ac), 32'h0002);
    check("cil_k4_e", 32'(e), 32'd1);
    check("cil_k4_done", 32'(done), 32'd1);
    model(4'd9, '0, 4'd3);
    after_done();

    // CME with valid held through the busy period: exactly one acceptance
    run_cmd(4'd6, 16'h0000, 4'd0); after_done();
    acc = 0;
    cmd_valid = 1'b1; cmd_op = 4'd7;
    for (int i = 0; i < 8; i++) begin
      if (cmd_valid && cmd_ready) acc++;
      if (done) cmd_valid = 1'b0;
      tick();
    end
    cmd_valid = 1'b0;
    model(4'd7, '0, 4'd0);
    check("held_accepts", 32'(acc), 32'd1);
    check("cme_e", 32'(e), 32'd1);

    run_cmd(4'd12, 16'h5555, 4'd7);
    check("rsv_ac", 32'(ac), 32'h0002);
    check("rsv_e", 32'(e), 32'd1);
    after_done();

    // Asynchronous reset between edges
    run_cmd(4'd2, 16'h5A5A, 4'd0); after_done();
    #3 rst = 1'b1;
    #1;
    check("arst_ac", 32'(ac), 32'h0);
    check("arst_e", 32'(e), 32'd0);
    check("arst_ready", 32'(cmd_ready), 32'd1);
    check("arst_done", 32'(done), 32'd0);
    check("arst_zero", 32'(flag_zero), 32'd1);
    tick();
    rst = 1'b0;
    ac_m = '0; e_m = 1'b0;

    // CIR 15 from 0001/E=1, aborted by reset in the 5th ROT cycle
    run_cmd(4'd2, 16'h0001, 4'd0); after_done();
    run_cmd(4'd7, 16'h0000, 4'd0); after_done();
    cmd_valid = 1'b1; cmd_op = 4'd8; cmd_data = '0; cmd_count = 4'd15;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("rot5_busy", 32'(cmd_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rotrst_ac", 32'(ac), 32'h0);
    check("rotrst_e", 32'(e), 32'd0);
    check("rotrst_done", 32'(done), 32'd0);
    tick();
    check("rotrst_done_edge", 32'(done), 32'd0);
    rst = 1'b0;
    ac_m = '0; e_m = 1'b0;
    check("rotrst_ready", 32'(cmd_ready), 32'd1);
    run_cmd(4'd2, 16'h1234, 4'd0);
    check("post_rst_ac", 32'(ac), 32'h1234);
    after_done();

    // Randomized commands against the reference model
    for (int i = 0; i < 80; i++) begin
      rop = 4'($urandom_range(0, 15));
      rd  = W'($urandom);
      rc  = 4'($urandom_range(0, 15));
      run_cmd(rop, rd, rc);
      check("rnd_ac", 32'(ac), 32'(ac_m));
      check("rnd_e", 32'(e), 32'(e_m));
      check("rnd_zero", 32'(flag_zero), 32'(ac_m == '0));
      check("rnd_neg", 32'(flag_neg), 32'(ac_m[W-1]));
      after_done();
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ac_sequencer.md
# ac_sequencer

Accumulator/E-flag sequencer that sits on the operand and opcode side of the ALU. It accepts register-reference commands from the control unit over a valid/ready handshake and drives the ALU's `a`, `b` and `alu_op` inputs. It captures the ALU result and carry into the AC and E registers, and performs multi-bit circular shifts (CIR/CIL) through E one bit per cycle. It pulses `done` when AC and E hold the final value.

## Interface
- `DATA_WIDTH`, default 16: AC, operand and ALU width.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer idle and able to accept.
- `cmd_op`  in  4  command code (see Operation).
- `cmd_data`  in  DATA_WIDTH  memory operand (MDR value), used by AND/ADD/LDA.
- `cmd_count`  in  4  rotate count for CIR/CIL, 0..15.
- `alu_a`  out  DATA_WIDTH  ALU operand A, equal to the AC register.
- `alu_b`  out  DATA_WIDTH  ALU operand B, equal to the latched cmd_data.
- `alu_op`  out  3  ALU operation select (registered).
- `alu_result`  in  DATA_WIDTH  ALU result.
- `alu_carry`  in  1  ALU carry out.
- `ac`  out  DATA_WIDTH  accumulator.
- `e`  out  1  extend/carry flag.
- `done`  out  1  one-cycle completion pulse.
- `flag_zero`  out  1  `ac == 0`, combinational from the register.
- `flag_neg`  out  1  `ac[DATA_WIDTH-1]`.

## Operation
- ALU op encodings:
  - AND=000, ADD=001, CMA=010, TRANSFER=101, INC=110, CLA=111.
- cmd_op map:
  - 0 AND: AC←AC&D, E unchanged.
  - 1 ADD: {E,AC}←AC+D.
  - 2 LDA: AC←D via TRANSFER, E unchanged.
  - 3 CMA: AC←~AC.
  - 4 INC: {E,AC}←AC+1.
  - 5 CLA: AC←0.
  - 6 CLE: E←0.
  - 7 CME: E←~E.
  - 8 CIR: repeated count times, AC←{E,AC[W-1:1]}, E←AC[0].
  - 9 CIL: repeated count times, AC←{AC[W-2:0],E}, E←AC[W-1].
  - 10–15: reserved; no state change, done still pulses.
- E is written from `alu_carry` only for ADD and INC. AND, LDA, CMA and CLA leave E unchanged.
- FSM states: IDLE, EXEC, ROT, DONE.
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op, data and count, and set alu_op. Go to ROT if op is 8/9 and count≠0, otherwise go to EXEC.
  - EXEC: one cycle. ALU drives from registered AC, latched D and alu_op. At the end of the cycle, AC/E are written per op; E-only ops (CLE/CME) apply here. Then go to DONE.
  - ROT: one bit rotated at the end of each cycle; a remaining counter decrements. After the last bit, go to DONE.
  - DONE: done=1, cmd_ready=0, one cycle, then go to IDLE.
- CIR/CIL with count 0 take the EXEC path with no change.
- cmd_valid outside IDLE is ignored (cmd_ready=0). The initiator holds the command until accepted.
- alu_op holds its last value between commands. Its value outside EXEC is don't-care to the datapath.
- Arithmetic is modulo 2^DATA_WIDTH; the carry goes to E only.

## Timing
- Reset values:
  - ac=0, e=0, alu_op=111, cmd_ready=1, done=0, state IDLE.
  - flag_zero=1, flag_neg=0.
- Reset asserted mid-command aborts immediately. AC/E clear, no done pulse, cmd_ready=1 once reset deasserts.
- Acceptance happens in cycle k (cmd_valid&cmd_ready high at that rising edge).
- Non-rotate commands:
  - EXEC in cycle k+1.
  - AC/E show the new value and done=1 in cycle k+2.
  - cmd_ready=1 again in cycle k+3.
- Rotate with count c≥1:
  - ROT in cycles k+1..k+c.
  - done=1 and final AC/E in cycle k+c+1.
  - Intermediate rotated values are visible each ROT cycle.
- Throughput: one non-rotate command every 3 cycles; one rotate every c+2 cycles.
- alu_a/alu_b are stable for the whole EXEC cycle (registered). The ALU path is single-cycle combinational.

## Test plan
- Reset: assert rst asynchronously mid-cycle → ac=0x0000, e=0, cmd_ready=1, done=0, flag_zero=1, without waiting for a clock edge.
- LDA 0x7FFF then INC → after INC, ac=0x8000, e=0, flag_neg=1. done in cycle k+2 of each accept; cmd_ready low during k+1..k+2.
- LDA 0xFFFF then ADD 0x0001 → ac=0x0000, e=1, flag_zero=1. A following AND 0x0000 keeps e=1.
- LDA 0xA000, CLE, then CIL count 3:
  - Per-cycle values: ac=0x4000/e=1, then 0x8001/0, then 0x0002/1.
  - done in cycle k+4.
- CME toggles e 0→1. Reserved op 12 leaves ac/e unchanged and still pulses done at k+2. A cmd_valid held high while busy is accepted exactly once.
- CIR count 15 from ac=0x0001, e=1 with rst asserted at the 5th ROT cycle → ac=0, e=0, no done; the next command is accepted normally.
